// File: rtl/barrel_shift_normalizer.sv
// barrel_shift_normalizer
//   Undoes a barrel shift by walking a 16-bit word back toward its aligned end
//   until the leading one (left mode) or trailing one (right mode) sits at the
//   edge. It reports the normalized word, the recovered byte and the number of
//   positions shifted.
//
// Optional feature macro: NORM_NIBBLE_SKIP_EN
//   When defined, a cycle whose four bits nearest the aligned end are all zero
//   shifts by 4 instead of 1. Results are identical; only latency shrinks.
//
// Ports
//   i_clk              clock, rising edge
//   i_res              asynchronous active-high reset
//   i_start            normalize request, sampled only while idle
//   i_direction_right  1: word was right-shifted, normalize left (to bit 15)
//                      0: word was left-shifted, normalize right (to bit 0)
//   i_word             word to normalize, captured on the accepting edge
//   o_busy             high while scanning
//   o_valid            one-cycle result strobe
//   o_word             normalized word (held until next o_valid)
//   o_data             o_word[15:8] for left mode, o_word[7:0] for right mode
//   o_shift_emount     number of bit positions shifted
//   o_zero             input word was all zeros (cleared on next accepted start)

module barrel_shift_normalizer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_res,
  input  logic             i_start,
  input  logic             i_direction_right,
  input  logic [WIDTH-1:0] i_word,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_word,
  output logic [7:0]       o_data,
  output logic [CNT_W-1:0] o_shift_emount,
  output logic             o_zero
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;   // 1 = normalize toward bit WIDTH-1
  logic             done;           // result completes on this edge
  logic             zero_hit;       // completing result is the all-zero word
  logic             zero_clr;       // new job accepted, drop the stale o_zero

  // Bit that must be set for the word to count as aligned, and the four bits
  // nearest the aligned end (used only by the nibble skip).
  logic             aligned;
  logic [3:0]       near_nib;

  assign aligned  = dir ? work[WIDTH-1] : work[0];
  assign near_nib = dir ? work[WIDTH-1 -: 4] : work[3:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    done      = 1'b0;
    zero_hit  = 1'b0;
    zero_clr  = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          work_nxt  = i_word;
          cnt_nxt   = '0;
          dir_nxt   = i_direction_right;
          zero_clr  = 1'b1;
          state_nxt = SCAN;
        end
      end

      SCAN: begin
        // Shifting only discards zeros, so an all-zero word can only be seen
        // on the first scan cycle; the count is still zero there.
        if (work == '0) begin
          done      = 1'b1;
          zero_hit  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (aligned) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
`ifdef NORM_NIBBLE_SKIP_EN
          // Nonzero word with an empty edge nibble: the aligning one is at
          // least four positions away, so a 4-bit jump cannot overshoot.
          if (near_nib == 4'h0) begin
            work_nxt = dir ? (work << 4) : (work >> 4);
            cnt_nxt  = cnt + CNT_W'(4);
          end else begin
            work_nxt = dir ? (work << 1) : (work >> 1);
            cnt_nxt  = cnt + CNT_W'(1);
          end
`else
          work_nxt = dir ? (work << 1) : (work >> 1);
          cnt_nxt  = cnt + CNT_W'(1);
`endif
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

`ifndef NORM_NIBBLE_SKIP_EN
  // near_nib only feeds the nibble skip; keep it visibly consumed otherwise.
  logic unused_near_nib;
  assign unused_near_nib = ^near_nib;
`endif

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      work <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
    end else begin
      work <= work_nxt;
      cnt  <= cnt_nxt;
      dir  <= dir_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: load on the completing edge, hold otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      o_valid        <= 1'b0;
      o_word         <= '0;
      o_data         <= '0;
      o_shift_emount <= '0;
      o_zero         <= 1'b0;
    end else begin
      o_valid <= done;
      if (done) begin
        o_word         <= work;
        o_data         <= dir ? work[WIDTH-1 -: 8] : work[7:0];
        o_shift_emount <= cnt_nxt;
        o_zero         <= zero_hit;
      end else if (zero_clr) begin
        o_zero <= 1'b0;
      end
    end
  end

  assign o_busy = (state == SCAN);

endmodule
